snoop_bus_initiator: RTL

//  Bus-side initiator for the MESI snoop bus: takes one miss/upgrade request from the local cache, arbitrates for the common bus,

---
 rtl/snoop_bus_initiator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/snoop_bus_initiator.sv
// snoop_bus_initiator: MESI snoop-bus request initiator; SNOOP_INIT_FLUSH_WB_EN adds flush write-back to memory
module snoop_bus_initiator #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SNOOP_WIN   = 4,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Req_valid,
    output logic              Req_ready,
    input  logic [1:0]        Req_type,
    input  logic [ADDR_W-1:0] Req_addr,
    output logic              Bus_req,
    input  logic              Bus_grant,
    output logic [ADDR_W-1:0] Address_Com,
    output logic              BusRd,
    output logic              BusRdX,
    output logic              Invalidate,
    input  logic              Shared,
    input  logic              Flush_valid,
    input  logic [DATA_W-1:0] Data_Bus_Com,
    output logic              Mem_rd_req,
    output logic [ADDR_W-1:0] Mem_addr,
    input  logic              Mem_rd_valid,
    input  logic [DATA_W-1:0] Mem_rd_data,
`ifdef SNOOP_INIT_FLUSH_WB_EN
    output logic              Mem_wr_req,
    output logic [DATA_W-1:0] Mem_wr_data,
    input  logic              Mem_wr_ack,
`endif
    output logic              Done,
    output logic [DATA_W-1:0] Done_data,
    output logic              Done_shared,
    output logic              Err
);
    localparam int CNT_MAX = (SNOOP_WIN > MEM_TIMEOUT) ? SNOOP_WIN : MEM_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SNOOP,
        WAIT,
        MEM,
`ifdef SNOOP_INIT_FLUSH_WB_EN
        WB,
`endif
        RESP
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        typ;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              shared_f;
    logic              err_f;
    logic [CW-1:0]     cnt;
    logic              flush_hit;

    assign flush_hit = Flush_valid && (typ != 2'b10);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // next-state and bus/memory/completion outputs
    always_comb begin
        state_nxt   = state;
        Req_ready   = 1'b0;
        Bus_req     = 1'b0;
        Address_Com = '0;
        BusRd       = 1'b0;
        BusRdX      = 1'b0;
        Invalidate  = 1'b0;
        Mem_rd_req  = 1'b0;
        Mem_addr    = '0;
        Done        = 1'b0;
        Done_data   = '0;
        Done_shared = 1'b0;
        Err         = 1'b0;
`ifdef SNOOP_INIT_FLUSH_WB_EN
        Mem_wr_req  = 1'b0;
        Mem_wr_data = '0;
`endif
        case (state)
            IDLE: begin
                Req_ready = 1'b1;
                if (Req_valid) state_nxt = (Req_type == 2'b11) ? RESP : ARB;
            end
            ARB: begin
                Bus_req = 1'b1;
                if (Bus_grant) state_nxt = SNOOP;
            end
            SNOOP: begin
                Bus_req     = 1'b1;
                Address_Com = addr;
                BusRd       = (typ == 2'b00);
                BusRdX      = (typ == 2'b01);
                Invalidate  = (typ == 2'b10);
                state_nxt   = WAIT;
            end
            WAIT: begin
                Bus_req = 1'b1;
`ifdef SNOOP_INIT_FLUSH_WB_EN
                if (flush_hit) state_nxt = WB;
`else
                if (flush_hit) state_nxt = RESP;
`endif
                else if (cnt == CW'(SNOOP_WIN - 1)) state_nxt = (typ == 2'b10) ? RESP : MEM;
            end
            MEM: begin
                Bus_req    = 1'b1;
                Mem_rd_req = 1'b1;
                Mem_addr   = addr;
                if (Mem_rd_valid || cnt == CW'(MEM_TIMEOUT - 1)) state_nxt = RESP;
            end
`ifdef SNOOP_INIT_FLUSH_WB_EN
            WB: begin
                Bus_req     = 1'b1;
                Mem_wr_req  = 1'b1;
                Mem_addr    = addr;
                Mem_wr_data = data;
                if (Mem_wr_ack) state_nxt = RESP;
            end
`endif
            RESP: begin
                Bus_req     = (typ != 2'b11);
                Done        = 1'b1;
                Done_data   = data;
                Done_shared = shared_f && (typ == 2'b00);
                Err         = err_f;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // request latch, snoop/memory result capture and phase counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            typ      <= '0;
            addr     <= '0;
            data     <= '0;
            shared_f <= 1'b0;
            err_f    <= 1'b0;
            cnt      <= '0;
        end else begin
            if (state == IDLE && Req_valid) begin
                typ      <= Req_type;
                addr     <= Req_addr;
                data     <= '0;
                shared_f <= 1'b0;
                err_f    <= (Req_type == 2'b11);
            end
            if (state == WAIT) begin
                if (Shared) shared_f <= 1'b1;
                if (flush_hit) begin
                    data <= Data_Bus_Com;
                    if (typ == 2'b00) shared_f <= 1'b1;
                end
            end
            if (state == MEM) begin
                if (Mem_rd_valid) data <= Mem_rd_data;
                else if (cnt == CW'(MEM_TIMEOUT - 1)) err_f <= 1'b1;
            end
            cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;
        end
    end
endmodule
